rv32i_ifetch: RTL
=================

Name: rv32i_ifetch

Overview:
- Instruction fetch stage directly upstream of the main control decoder in the single-cycle RV32I core.
- Holds the PC and issues one request at a time to a variable-latency instruction memory over a valid/ready request and valid response interface.
- Presents the fetched instruction (and its opcode field) until the core retires it, then advances the PC to PC+4 or to the resolved branch target.
- Detects response timeout and misaligned branch targets; on either, it halts in a sticky error state.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TIMEOUT, 16, maximum cycles spent in S_WAIT before fetch_err is raised; 0 disables the timeout.
- CNT_W, 8, width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  input  1  core clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- imem_req_valid  output  1  fetch request valid.
- imem_req_ready  input  1  memory accepts the request.
- imem_req_addr  output  32  fetch address; always equals pc.
- imem_rsp_valid  input  1  response data valid.
- imem_rsp_data  input  32  instruction word.
- inst_valid  output  1  inst, opcode and inst_pc are valid.
- inst  output  32  current instruction.
- opcode  output  7  inst[6:0], feeds the control decoder.
- inst_pc  output  32  address of inst.
- inst_ready  input  1  core retires inst this cycle.
- branch_taken  input  1  Branch & ALU zero; sampled only on retire.
- branch_target  input  32  inst_pc + B-immediate; sampled only on retire.
- fetch_err  output  1  sticky error flag.

Behaviour:
- Reset is asynchronous on rst_n low:
  - pc=RESET_PC, state=S_REQ.
  - imem_req_valid=0 while rst_n is low.
  - inst_valid=0, inst=32'h0000_0013 (NOP), inst_pc=RESET_PC, fetch_err=0, wait counter=0.
  - Reset mid-transaction abandons any outstanding request. Any response that arrives later is ignored because the block is in S_REQ.
- State S_REQ:
  - imem_req_valid=1, imem_req_addr=pc.
  - Valid and address stay stable until imem_req_ready; the request is never withdrawn.
  - On valid&ready: go to S_WAIT and clear the counter.
- State S_WAIT:
  - imem_req_valid=0.
  - On imem_rsp_valid: latch inst<=imem_rsp_data and inst_pc<=pc, then go to S_HOLD.
  - Otherwise the counter increments. If TIMEOUT!=0 and the counter reaches TIMEOUT-1 with no response in that cycle: go to S_ERR and set fetch_err.
  - A response in the same cycle as the timeout wins; no error is raised.
- State S_HOLD:
  - inst_valid=1; inst and inst_pc are held stable.
  - On inst_ready:
    - If branch_taken=1 and branch_target[1:0]!=0: go to S_ERR, set fetch_err, leave pc unchanged.
    - Else pc<=branch_taken ? branch_target : pc+4, go to S_REQ.
    - inst_valid drops the next cycle.
- State S_ERR:
  - All valids are 0, fetch_err=1, pc is frozen.
  - Exit only by reset.
- imem_rsp_valid outside S_WAIT is ignored and not counted as an error.
- branch_taken and branch_target are ignored unless the block is in S_HOLD with inst_ready=1.
- pc+4 wraps modulo 2^32: 32'hFFFF_FFFC -> 32'h0000_0000.
- Minimum throughput is one instruction per 3 cycles: req accepted, rsp, retire.
- Only one request is outstanding; no prefetch.
- All outputs are registered except imem_req_addr (=pc) and opcode (=inst[6:0]).

Decomposition:
- Shared package rv32i_pkg holds:
  - Fetch state enum: S_REQ, S_WAIT, S_HOLD, S_ERR.
  - NOP constant 32'h0000_0013.
  - Opcode constants: OP_R 7'b0110011, OP_LOAD 7'b0000011, OP_STORE 7'b0100011, OP_BRANCH 7'b1100011, shared with the control decoder.
- Single module; no sub-module is warranted. The wait counter is inline.

Test Plan:
- Reset with RESET_PC=0x100; memory grants at once and responds 1 cycle later -> req at 0x100; inst_valid after 3 cycles with inst_pc=0x100 and opcode as supplied; next req at 0x104 after inst_ready.
- imem_req_ready held low for 5 cycles -> imem_req_valid=1 and addr=0x100 stable throughout; exactly one transaction issued.
- Retire a beq with branch_taken=1, branch_target=0x0F0 -> next req addr=0x0F0; branch_taken=1 pulsed outside S_HOLD has no effect.
- branch_taken=1, branch_target=0x0F2 at retire -> fetch_err=1, all valids 0; stuck until rst_n is pulsed low, then fetch restarts at RESET_PC.
- TIMEOUT=16, no response -> fetch_err=1 after exactly 16 cycles in S_WAIT; response on cycle 16 -> no error, normal hold.
- pc=0xFFFF_FFFC, retire with no branch -> next req addr=0x0000_0000; rst_n asserted during S_WAIT -> late response ignored, req reissued at RESET_PC.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: fetch state encoding, the NOP word and the
// major opcode values that the fetch stage and control decoder agree on.
package rv32i_pkg;

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_ERR
    } fetch_state_e;

    // addi x0, x0, 0 - shown on inst while nothing has been fetched yet
    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // Instruction addresses must be word aligned (no compressed ISA)
    function automatic logic is_word_aligned(input logic [31:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/rv32i_ifetch.sv
// Instruction fetch stage: keeps the PC, fetches one word at a time from a
// variable-latency instruction memory, holds it until the core retires it,
// then moves on to PC+4 or the branch target. A response timeout or a
// misaligned branch target parks the block in a sticky error state.
module rv32i_ifetch
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          TIMEOUT  = 16,
    parameter int          CNT_W    = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [6:0]  opcode,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        fetch_err
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    fetch_state_e     state;
    logic [31:0]      pc;
    logic [CNT_W-1:0] wait_cnt;

    assign imem_req_addr = pc;
    assign opcode        = inst[6:0];

    // Fetch FSM with all stage outputs registered alongside the state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= S_REQ;
            pc             <= RESET_PC;
            wait_cnt       <= '0;
            imem_req_valid <= 1'b0;
            inst_valid     <= 1'b0;
            inst           <= NOP;
            inst_pc        <= RESET_PC;
            fetch_err      <= 1'b0;
        end else begin
            case (state)
                S_REQ: begin
                    if (imem_req_valid && imem_req_ready) begin
                        imem_req_valid <= 1'b0;
                        wait_cnt       <= '0;
                        state          <= S_WAIT;
                    end else begin
                        imem_req_valid <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        inst       <= imem_rsp_data;
                        inst_pc    <= pc;
                        inst_valid <= 1'b1;
                        state      <= S_HOLD;
                    end else if ((TIMEOUT != 0) && (wait_cnt == CNT_LAST)) begin
                        fetch_err <= 1'b1;
                        state     <= S_ERR;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (inst_ready) begin
                        inst_valid <= 1'b0;
                        if (branch_taken && !is_word_aligned(branch_target)) begin
                            fetch_err <= 1'b1;
                            state     <= S_ERR;
                        end else begin
                            pc             <= branch_taken ? branch_target : pc + 32'd4;
                            imem_req_valid <= 1'b1;
                            state          <= S_REQ;
                        end
                    end
                end
                S_ERR: begin
                    imem_req_valid <= 1'b0;
                    inst_valid     <= 1'b0;
                    fetch_err      <= 1'b1;
                end
                default: begin
                    imem_req_valid <= 1'b0;
                    inst_valid     <= 1'b0;
                    fetch_err      <= 1'b1;
                    state          <= S_ERR;
                end
            endcase
        end
    end

endmodule
